lvds_rx_deframer: RTL and testbench
===================================

Name: lvds_rx_deframer

Overview:
Parametrised receive-side link engine behind the LVDS rx SERDES macro, running on rx_outclock.
- Trains word alignment by pulsing rx_data_align and acquires a sync word.
- Deframes header-tagged words of WORD_W bits carried over LANE_W-bit beats, with parity check.
- Detects loss of sync and retrains automatically; delivers words to the downstream FIFO via the EN/RDY handshake.
- Generalises the fixed 4-bit/32-bit receive FSM with explicit valid/parity headers, error counters, drop accounting and retraining.

Parameters:
- LANE_W, 4: bits per rx_out beat (SERDES deserialisation factor).
- WORD_W, 32: payload word width; must be a multiple of LANE_W; BEATS = WORD_W/LANE_W.
- TRAIN_PAT, 4'b0001: training beat (LANE_W bits).
- SYNC_PAT, 4'b0111: sync beat (LANE_W bits).
- ALIGN_HOLD, 6: cycles rx_out is ignored after each rx_data_align pulse.
- TRAIN_STABLE, 4: consecutive TRAIN_PAT beats required to declare alignment.
- LOS_THRESH, 3: consecutive bad headers that force retraining.

Ports:
- rx_outclock, in, 1: sole clock.
- reset, in, 1: synchronous, active-high reset.
- rx_locked, in, 1: rx PLL lock from the SERDES.
- rx_out, in, LANE_W: parallel beat from the SERDES.
- rx_data_align, out, 1: bitslip request pulse to the SERDES.
- RDY_for_trans, out, 1: back-channel ready to the far transmitter.
- deq_rx, out, WORD_W: received payload word.
- EN_deq_rx, out, 1: one-cycle enqueue strobe to the downstream FIFO.
- RDY_deq_rx, in, 1: downstream FIFO not full.
- link_up, out, 1: high in HEADER/PAYLOAD.
- parity_err_cnt, out, 8: saturating parity-error count.
- drop_cnt, out, 8: saturating count of valid words dropped.
- state_out, out, 3: FSM state encoding for LEDs.

Behaviour:
- Reset (sync, high) forces:
  - state TRAIN;
  - all outputs 0: deq_rx, EN_deq_rx, rx_data_align, RDY_for_trans, link_up, both counters;
  - internal slip/hold/stable/LOS counters 0.
- Reset mid-frame discards the partial word; no EN_deq_rx is issued.
- Frame format: 1 header beat followed by BEATS payload beats, MSB-first (first beat = deq_rx[WORD_W-1 -: LANE_W]).
- Header bits:
  - [LANE_W-1] = valid;
  - [LANE_W-2:1] = marker 10..0 (pattern 1 then zeros); for LANE_W=4 the header is {v,1,0,p};
  - [0] = even parity over the payload.
- Frames are back-to-back. Idle frames have valid=0.
- States and transitions (state_out value):
  - TRAIN (0): on rx_out==TRAIN_PAT, increment stable; at TRAIN_STABLE go WAIT_SYNC. On a mismatch outside hold: pulse rx_data_align high for exactly 1 cycle, clear stable, load hold=ALIGN_HOLD. rx_out is ignored while hold>0.
  - WAIT_SYNC (1): RDY_for_trans = RDY_deq_rx. TRAIN_PAT stays here; SYNC_PAT goes to HEADER; any other value goes to TRAIN.
  - HEADER (2): check the marker.
    - Good: latch valid and parity, clear LOS, go PAYLOAD.
    - Bad: LOS+1, stay HEADER; at LOS_THRESH go TRAIN.
  - PAYLOAD (3): shift a beat into the word register each cycle; beat counter 0..BEATS-1. After the last beat go HEADER.
- Output timing:
  - deq_rx is updated, and EN_deq_rx asserted for 1 cycle, on the cycle after the last payload beat is sampled.
  - Latency from the last beat on rx_out to the EN_deq_rx edge: 1 cycle.
- Word completion rules:
  - valid=1 and parity OK and RDY_deq_rx=1: EN_deq_rx=1.
  - valid=1 and parity OK and RDY_deq_rx=0: word dropped, drop_cnt+1.
  - Parity fail: parity_err_cnt+1, no EN (regardless of valid).
  - valid=0: no EN, no count.
- Counters saturate at 255 and are cleared only by reset.
- RDY_for_trans = RDY_deq_rx in WAIT_SYNC/HEADER/PAYLOAD; 0 in TRAIN.
- rx_locked=0 in any state: go TRAIN next cycle, abort any frame (no EN), counters retained. While rx_locked=0, no rx_data_align pulses are issued.
- Simultaneous reset and any event: reset wins.

Test Plan:
- Training: TRAIN_PAT arrives only after 2 slips (stream rotated by 2) -> exactly 2 single-cycle rx_data_align pulses ≥7 cycles apart; then 4× 0001 -> state_out=1.
- Valid frame: 0111, header 4'b1100, payload 0xDEADBEEF (even parity, p=0) with RDY_deq_rx=1 -> deq_rx=0xDEADBEEF and EN_deq_rx=1 for 1 cycle, 1 cycle after the last beat; link_up=1.
- Parity error: header 4'b1101 with payload 0xDEADBEEF -> no EN_deq_rx, parity_err_cnt=1, deq_rx unchanged.
- Back-pressure: valid frame 0x00000003 with RDY_deq_rx=0 -> no EN, drop_cnt=1, RDY_for_trans=0; a following idle frame (header 0x4) -> no count change.
- Loss of sync: 3 consecutive headers 4'b0000 -> state_out=0, RDY_for_trans=0, and a mismatch causes rx_data_align to pulse.
- Lock loss and reset: drop rx_locked at payload beat 3 -> no EN, state TRAIN, counters kept; assert reset mid-PAYLOAD -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/lvds_rx_deframer.sv
// Receive link engine behind the LVDS rx SERDES. It trains word alignment, acquires sync,
// deframes header-tagged words with parity, and hands completed words to the downstream FIFO.
module lvds_rx_deframer #(
   parameter int unsigned        LANE_W       = 4,
   parameter int unsigned        WORD_W       = 32,
   parameter logic [LANE_W-1:0]  TRAIN_PAT    = 4'b0001,
   parameter logic [LANE_W-1:0]  SYNC_PAT     = 4'b0111,
   parameter int unsigned        ALIGN_HOLD   = 6,
   parameter int unsigned        TRAIN_STABLE = 4,
   parameter int unsigned        LOS_THRESH   = 3
) (
   input  logic              rx_outclock,
   input  logic              reset,
   input  logic              rx_locked,
   input  logic [LANE_W-1:0] rx_out,
   output logic              rx_data_align,
   output logic              RDY_for_trans,
   output logic [WORD_W-1:0] deq_rx,
   output logic              EN_deq_rx,
   input  logic              RDY_deq_rx,
   output logic              link_up,
   output logic [7:0]        parity_err_cnt,
   output logic [7:0]        drop_cnt,
   output logic [2:0]        state_out
);

   localparam int unsigned BEATS  = WORD_W / LANE_W;
   localparam int unsigned HOLD_W = $clog2(ALIGN_HOLD + 1);
   localparam int unsigned STAB_W = $clog2(TRAIN_STABLE + 1);
   localparam int unsigned LOS_W  = $clog2(LOS_THRESH + 1);
   localparam int unsigned BEAT_W = $clog2(BEATS + 1);
   // Header marker field [LANE_W-2:1] is a single 1 followed by zeros.
   localparam logic [LANE_W-3:0] MARKER = (LANE_W-2)'(1 << (LANE_W - 3));

   typedef enum logic [2:0] {
      ST_TRAIN     = 3'd0,
      ST_WAIT_SYNC = 3'd1,
      ST_HEADER    = 3'd2,
      ST_PAYLOAD   = 3'd3
   } state_t;

   state_t              state_q,  state_d;
   logic [HOLD_W-1:0]   hold_q,   hold_d;
   logic [STAB_W-1:0]   stable_q, stable_d;
   logic [LOS_W-1:0]    los_q,    los_d;
   logic [BEAT_W-1:0]   beat_q,   beat_d;
   logic [WORD_W-1:0]   word_q,   word_d;
   logic [WORD_W-1:0]   deq_q,    deq_d;
   logic                hv_q,     hv_d;
   logic                hp_q,     hp_d;
   logic                en_q,     en_d;
   logic                align_q,  align_d;
   logic [7:0]          perr_q,   perr_d;
   logic [7:0]          drop_q,   drop_d;
   logic [WORD_W-1:0]   full_word;

   assign full_word = {word_q[WORD_W-LANE_W-1:0], rx_out};

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      stable_d = stable_q;
      los_d    = los_q;
      beat_d   = beat_q;
      word_d   = word_q;
      deq_d    = deq_q;
      hv_d     = hv_q;
      hp_d     = hp_q;
      en_d     = 1'b0;
      align_d  = 1'b0;
      perr_d   = perr_q;
      drop_d   = drop_q;

      if (!rx_locked) begin
         // Lock loss aborts everything in flight; only the error counters survive.
         state_d  = ST_TRAIN;
         hold_d   = '0;
         stable_d = '0;
         los_d    = '0;
         beat_d   = '0;
      end else begin
         unique case (state_q)
            ST_TRAIN: begin
               if (hold_q != '0) begin
                  hold_d = hold_q - HOLD_W'(1);
               end else if (rx_out == TRAIN_PAT) begin
                  if (stable_q == STAB_W'(TRAIN_STABLE - 1)) begin
                     stable_d = '0;
                     state_d  = ST_WAIT_SYNC;
                  end else begin
                     stable_d = stable_q + STAB_W'(1);
                  end
               end else begin
                  align_d  = 1'b1;
                  stable_d = '0;
                  hold_d   = HOLD_W'(ALIGN_HOLD);
               end
            end
            ST_WAIT_SYNC: begin
               if (rx_out == SYNC_PAT) begin
                  state_d = ST_HEADER;
               end else if (rx_out != TRAIN_PAT) begin
                  state_d = ST_TRAIN;
               end
            end
            ST_HEADER: begin
               if (rx_out[LANE_W-2:1] == MARKER) begin
                  hv_d    = rx_out[LANE_W-1];
                  hp_d    = rx_out[0];
                  los_d   = '0;
                  beat_d  = '0;
                  state_d = ST_PAYLOAD;
               end else if (los_q == LOS_W'(LOS_THRESH - 1)) begin
                  los_d   = '0;
                  state_d = ST_TRAIN;
               end else begin
                  los_d = los_q + LOS_W'(1);
               end
            end
            ST_PAYLOAD: begin
               word_d = full_word;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  beat_d  = '0;
                  state_d = ST_HEADER;
                  if ((^full_word) != hp_q) begin
                     if (perr_q != 8'hFF) perr_d = perr_q + 8'd1;
                  end else if (hv_q) begin
                     if (RDY_deq_rx) begin
                        en_d  = 1'b1;
                        deq_d = full_word;
                     end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                     end
                  end
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
            default: state_d = ST_TRAIN;
         endcase
      end
   end

   always_ff @(posedge rx_outclock) begin
      if (reset) begin
         state_q  <= ST_TRAIN;
         hold_q   <= '0;
         stable_q <= '0;
         los_q    <= '0;
         beat_q   <= '0;
         word_q   <= '0;
         deq_q    <= '0;
         hv_q     <= 1'b0;
         hp_q     <= 1'b0;
         en_q     <= 1'b0;
         align_q  <= 1'b0;
         perr_q   <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         stable_q <= stable_d;
         los_q    <= los_d;
         beat_q   <= beat_d;
         word_q   <= word_d;
         deq_q    <= deq_d;
         hv_q     <= hv_d;
         hp_q     <= hp_d;
         en_q     <= en_d;
         align_q  <= align_d;
         perr_q   <= perr_d;
         drop_q   <= drop_d;
      end
   end

   assign rx_data_align  = align_q;
   assign EN_deq_rx      = en_q;
   assign deq_rx         = deq_q;
   assign parity_err_cnt = perr_q;
   assign drop_cnt       = drop_q;
   assign state_out      = state_q;
   assign link_up        = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
   assign RDY_for_trans  = (state_q != ST_TRAIN) && RDY_deq_rx;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer: expected words go into a scoreboard queue,
// and a negedge monitor pops and compares on every EN_deq_rx strobe.
module tb_lvds_rx_deframer;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_locked;
   logic [3:0]  rx_out;
   logic        rx_data_align;
   logic        RDY_for_trans;
   logic [31:0] deq_rx;
   logic        EN_deq_rx;
   logic        RDY_deq_rx;
   logic        link_up;
   logic [7:0]  parity_err_cnt;
   logic [7:0]  drop_cnt;
   logic [2:0]  state_out;

   int          checks = 0;
   int          errors = 0;
   int          n_en   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   lvds_rx_deframer #(
      .LANE_W      (4),
      .WORD_W      (32),
      .TRAIN_PAT   (4'b0001),
      .SYNC_PAT    (4'b0111),
      .ALIGN_HOLD  (6),
      .TRAIN_STABLE(4),
      .LOS_THRESH  (3)
   ) dut (
      .rx_outclock   (clk),
      .reset         (reset),
      .rx_locked     (rx_locked),
      .rx_out        (rx_out),
      .rx_data_align (rx_data_align),
      .RDY_for_trans (RDY_for_trans),
      .deq_rx        (deq_rx),
      .EN_deq_rx     (EN_deq_rx),
      .RDY_deq_rx    (RDY_deq_rx),
      .link_up       (link_up),
      .parity_err_cnt(parity_err_cnt),
      .drop_cnt      (drop_cnt),
      .state_out     (state_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every enqueue strobe must match the next expected word.
   always @(negedge clk) begin
      if (EN_deq_rx === 1'b1) begin
         n_en++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_en: got deq_rx 0x%0h expected no strobe", deq_rx);
         end else begin
            mon_exp = exp_q.pop_front();
            check("deq_rx", deq_rx, mon_exp);
         end
      end
   end

   task automatic beat(input logic [3:0] b);
      rx_out = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [3:0] hdr, input logic [31:0] w,
                             input bit exp_en, input bit rdy);
      logic [31:0] wv;
      wv = w;
      RDY_deq_rx = rdy;
      if (exp_en) exp_q.push_back(w);
      beat(hdr);
      check("link_up_frame", link_up, 1);
      check("rdy_for_trans_frame", RDY_for_trans, rdy);
      for (int i = 7; i >= 0; i--) beat(wv[i*4 +: 4]);
      check("en_latency", EN_deq_rx, exp_en);
   endtask

   task automatic train_up();
      for (int i = 0; i < 30 && state_out != 3'd1; i++) beat(4'b0001);
      check("train_up_state", state_out, 3'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      int last_pulse;
      int wide;
      int rot;
      bit prev_align;
      int stray;

      reset      = 1'b1;
      rx_locked  = 1'b1;
      rx_out     = 4'h0;
      RDY_deq_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_out, 0);
      check("rst_en", EN_deq_rx, 0);
      check("rst_deq", deq_rx, 0);
      check("rst_align", rx_data_align, 0);
      check("rst_rdy_for_trans", RDY_for_trans, 0);
      check("rst_link_up", link_up, 0);
      check("rst_perr", parity_err_cnt, 0);
      check("rst_drop", drop_cnt, 0);
      reset = 1'b0;

      // Training against a stream rotated by two bit positions.
      pulses = 0; last_pulse = -100; wide = 0; rot = 2; prev_align = 1'b0;
      for (int cyc = 0; cyc < 60 && state_out != 3'd1; cyc++) begin
         beat(4'b0001 << rot);
         if (rx_data_align) begin
            if (prev_align) wide++;
            pulses++;
            if (pulses > 1) check("align_spacing_ge7", (cyc - last_pulse) >= 7, 1);
            last_pulse = cyc;
            if (rot > 0) rot--;
         end
         prev_align = rx_data_align;
      end
      check("align_pulses", pulses, 2);
      check("align_width", wide, 0);
      check("train_state", state_out, 3'd1);
      check("wait_sync_rdy", RDY_for_trans, 1);

      beat(4'b0111);
      check("sync_state", state_out, 3'd2);
      check("sync_link_up", link_up, 1);

      send_frame(4'b1100, 32'hDEADBEEF, 1'b1, 1'b1);
      check("after_frame_state", state_out, 3'd2);

      send_frame(4'b1101, 32'hDEADBEEF, 1'b0, 1'b1);
      check("perr_cnt", parity_err_cnt, 1);
      check("deq_hold_on_perr", deq_rx, 32'hDEADBEEF);

      send_frame(4'b1100, 32'h00000003, 1'b0, 1'b0);
      check("drop_cnt", drop_cnt, 1);
      send_frame(4'b0100, 32'h00000000, 1'b0, 1'b0);
      check("idle_drop", drop_cnt, 1);
      check("idle_perr", parity_err_cnt, 1);

      send_frame(4'b1101, 32'h00000001, 1'b1, 1'b1);
      check("odd_word_deq", deq_rx, 32'h00000001);

      // Loss of sync from three bad headers.
      beat(4'b0000);
      check("los1_state", state_out, 3'd2);
      beat(4'b0000);
      check("los2_state", state_out, 3'd2);
      beat(4'b0000);
      check("los3_state", state_out, 3'd0);
      check("los3_rdy", RDY_for_trans, 0);
      check("los3_link", link_up, 0);
      beat(4'b0100);
      check("los_align_pulse", rx_data_align, 1);
      train_up();

      // Lock loss at payload beat 3.
      beat(4'b0111);
      beat(4'b1100);
      beat(4'hC); beat(4'hA); beat(4'hF);
      rx_locked = 1'b0;
      beat(4'hE);
      check("lock_state", state_out, 3'd0);
      check("lock_perr_kept", parity_err_cnt, 1);
      check("lock_drop_kept", drop_cnt, 1);
      check("lock_link_up", link_up, 0);
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         beat(4'b0100);
         if (rx_data_align) stray++;
      end
      check("no_align_unlocked", stray, 0);
      check("unlocked_state", state_out, 3'd0);
      rx_locked = 1'b1;
      train_up();

      // Reset mid-payload.
      beat(4'b0111);
      beat(4'b1100);
      beat(4'h1); beat(4'h2); beat(4'h3);
      reset = 1'b1;
      beat(4'h4);
      check("mid_rst_state", state_out, 0);
      check("mid_rst_deq", deq_rx, 0);
      check("mid_rst_en", EN_deq_rx, 0);
      check("mid_rst_perr", parity_err_cnt, 0);
      check("mid_rst_drop", drop_cnt, 0);
      check("mid_rst_link", link_up, 0);
      check("mid_rst_rdy", RDY_for_trans, 0);
      check("mid_rst_align", rx_data_align, 0);
      reset = 1'b0;
      repeat (4) beat(4'h5);

      check("scoreboard_empty", exp_q.size(), 0);
      check("en_strobes", n_en, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
